// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register file's single write
// port between two requesters. Every output is a flop, and a request whose
// ack is going out this cycle is masked so it is never written twice.
module rf_write_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              ack0,
  output logic              ack1,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WIDTH-1:0]  rf_data,
  output logic [CNT_W-1:0]  write_count
);

  logic last_grant;
  logic elig0;
  logic elig1;
  logic grant_any;
  logic winner;

  // Eligibility masks a request whose ack is being delivered; on contention
  // the requester that did not win last time gets the port.
  always_comb begin
    elig0     = req0 & ~ack0;
    elig1     = req1 & ~ack1;
    grant_any = elig0 | elig1;
    winner    = 1'b0;
    if (elig0 && elig1) begin
      winner = ~last_grant;
    end else if (elig1) begin
      winner = 1'b1;
    end
  end

  // Registered write port, acks, grant history and saturating write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      write_count <= '0;
      last_grant  <= 1'b1;
    end else if (grant_any) begin
      rf_we      <= 1'b1;
      rf_addr    <= winner ? addr1 : addr0;
      rf_data    <= winner ? data1 : data0;
      ack0       <= ~winner;
      ack1       <= winner;
      last_grant <= winner;
      if (write_count != {CNT_W{1'b1}}) begin
        write_count <= write_count + 1'b1;
      end
    end else begin
      rf_we <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench. A reference model pushes the expected
// outputs for every clock edge into a queue; a monitor on the falling edge
// pops one entry per cycle and compares it with two DUT instances (default
// counter width and a 2-bit counter that saturates quickly).
module tb_rf_write_arbiter;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [WIDTH-1:0]  data0 = '0;
  logic [WIDTH-1:0]  data1 = '0;

  logic              ack0, ack1, rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_data;
  logic [15:0]       write_count;

  logic              s_ack0, s_ack1, s_rf_we;
  logic [ADDR_W-1:0] s_rf_addr;
  logic [WIDTH-1:0]  s_rf_data;
  logic [1:0]        s_write_count;

  rf_write_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .rf_we(rf_we),
    .rf_addr(rf_addr), .rf_data(rf_data), .write_count(write_count)
  );

  rf_write_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .ack0(s_ack0), .ack1(s_ack1), .rf_we(s_rf_we),
    .rf_addr(s_rf_addr), .rf_data(s_rf_data), .write_count(s_write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int we;
    int a0;
    int a1;
    int addr;
    int data;
    int cnt;
    int cnt_sat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: who holds an ack this cycle, who won last, counters.
  bit m_ack0 = 1'b0;
  bit m_ack1 = 1'b0;
  int m_last = 1;
  int m_cnt = 0;
  int m_cnt_sat = 0;
  int m_addr = 0;
  int m_data = 0;

  // Reference model: decide each edge's write from the sampled requests.
  always @(posedge clk) begin : model
    exp_t e;
    bit el0, el1;
    int win;
    if (reset) begin
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_last = 1;
      m_cnt = 0; m_cnt_sat = 0; m_addr = 0; m_data = 0;
      e.we = 0;
    end else begin
      el0 = req0 && !m_ack0;
      el1 = req1 && !m_ack1;
      win = -1;
      if (el0 && el1) win = 1 - m_last;
      else if (el0) win = 0;
      else if (el1) win = 1;
      m_ack0 = (win == 0);
      m_ack1 = (win == 1);
      e.we = (win >= 0) ? 1 : 0;
      if (win >= 0) begin
        m_last = win;
        m_addr = (win == 1) ? int'(addr1) : int'(addr0);
        m_data = (win == 1) ? int'(data1) : int'(data0);
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt_sat < 3) m_cnt_sat = m_cnt_sat + 1;
      end
    end
    e.a0 = m_ack0 ? 1 : 0;
    e.a1 = m_ack1 ? 1 : 0;
    e.addr = m_addr;
    e.data = m_data;
    e.cnt = m_cnt;
    e.cnt_sat = m_cnt_sat;
    q.push_back(e);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = q.pop_front();
      check("rf_we", int'(rf_we), e.we);
      check("ack0", int'(ack0), e.a0);
      check("ack1", int'(ack1), e.a1);
      check("rf_addr", int'(rf_addr), e.addr);
      check("rf_data", int'(rf_data), e.data);
      check("write_count", int'(write_count), e.cnt);
      check("sat_rf_we", int'(s_rf_we), e.we);
      check("sat_write_count", int'(s_write_count), e.cnt_sat);
    end
  endtask

  // Monitor: one expected record per cycle, compared away from the rising edge.
  always @(negedge clk) begin : monitor
    checkOutput();
  end

  // Drive one transaction per requester and release each once its ack is seen.
  task automatic applyStimulus(input bit r0, input int a0, input int d0,
                               input bit r1, input int a1, input int d1);
    int n;
    req0 = r0; addr0 = ADDR_W'(a0); data0 = WIDTH'(d0);
    req1 = r1; addr1 = ADDR_W'(a1); data1 = WIDTH'(d1);
    n = 0;
    while ((req0 || req1) && n < 10) begin
      @(negedge clk);
      if (m_ack0) req0 = 1'b0;
      if (m_ack1) req1 = 1'b0;
      n++;
    end
    if (req0 || req1) begin
      check("handshake_timeout", 0, 1);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  initial begin
    // Reset held two edges with both requesting: outputs must stay zero.
    reset = 1'b1;
    req0 = 1'b1; addr0 = 3'd1; data0 = 8'h11;
    req1 = 1'b1; addr1 = 3'd2; data1 = 8'h22;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Contention after release: requester 0 first, then 1.
    applyStimulus(1, 1, 8'h11, 1, 2, 8'h22);
    // Same address from both: 0x0F lands first, then 0xF0.
    applyStimulus(1, 5, 8'h0F, 1, 5, 8'hF0);
    // Single requester.
    applyStimulus(1, 3, 8'hA5, 0, 0, 0);
    @(negedge clk);
    // Continuous contention with fresh data after every ack.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_ack0) begin addr0 = ADDR_W'($urandom); data0 = WIDTH'($urandom); end
      if (m_ack1) begin addr1 = ADDR_W'($urandom); data1 = WIDTH'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset lands on the edge that samples req1; it must be written after release.
    req1 = 1'b1; addr1 = 3'd4; data1 = 8'h44; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 4, 8'h44);
    // Randomized traffic with occasional mid-operation resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (req0 && m_ack0) begin
        if ($urandom_range(0, 1) == 1) begin
          addr0 = ADDR_W'($urandom); data0 = WIDTH'($urandom);
        end else begin
          req0 = 1'b0;
        end
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; addr0 = ADDR_W'($urandom); data0 = WIDTH'($urandom);
      end
      if (req1 && m_ack1) begin
        if ($urandom_range(0, 1) == 1) begin
          addr1 = ADDR_W'($urandom); data1 = WIDTH'($urandom);
        end else begin
          req1 = 1'b0;
        end
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; addr1 = ADDR_W'($urandom); data1 = WIDTH'($urandom);
      end
      reset = ($urandom_range(0, 60) == 0);
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter that shares the register file's single write port between two requesters, such as the ALU writeback path and the memory-load path. It samples registered req/addr/data from each requester and drives one registered write per cycle (rf_we, rf_addr, rf_data) into the register file's write-enabled registers. It returns a one-cycle ack to the winning requester and keeps a saturating count of completed writes.

## Interface
- WIDTH, 8, data width of a register file entry
- ADDR_W, 3, register address width (2^ADDR_W entries)
- CNT_W, 16, width of the write counter
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
- req0  in  1  requester 0 write request; level, held until ack0 seen
- addr0  in  ADDR_W  requester 0 destination register; stable while req0=1
- data0  in  WIDTH  requester 0 write data; stable while req0=1
- req1, addr1, data1  in  1/ADDR_W/WIDTH  same for requester 1
- ack0  out  1  one-cycle pulse: requester 0 write is being performed this cycle
- ack1  out  1  one-cycle pulse: requester 1 write is being performed this cycle
- rf_we  out  1  register file write enable (registered)
- rf_addr  out  ADDR_W  register file write address (registered)
- rf_data  out  WIDTH  register file write data (registered)
- write_count  out  CNT_W  number of writes issued, saturating at all-ones

## Operation
- State: last_grant (1 bit), output registers rf_we/rf_addr/rf_data/ack0/ack1, write_count.
- Reset values: rf_we=0, rf_addr=0, rf_data=0, ack0=0, ack1=0, write_count=0, last_grant=1 (requester 0 wins the first contention).
- Eligibility per edge:
  - reqN counts only if reqN=1 and ackN=0 in the current cycle.
  - This masks a request whose ack is being delivered, so the same request is never granted twice.
- Arbitration at each rising edge, reset=0:
  - Neither eligible: rf_we<=0, ack0<=0, ack1<=0. rf_addr/rf_data hold their previous values. last_grant is unchanged.
  - Exactly one eligible: that requester wins.
  - Both eligible: the requester other than last_grant wins.
  - Winner N: rf_we<=1, rf_addr<=addrN, rf_data<=dataN, ackN<=1, the other ack<=0, last_grant<=N, write_count<=write_count+1 unless already all-ones.
- Same-address writes from both requesters are not merged. Both are performed in grant order, so the later grant's data ends in the register.
- No combinational path from any input to any output. All outputs come straight from flops.
- Reset mid-operation:
  - Reset forces the reset values on the next edge, regardless of req.
  - Any write whose ack had not yet been seen is dropped.
  - The requester keeps req high and is re-arbitrated after reset releases.

## Timing
- Latency: req sampled at edge k → rf_we/ackN high during cycle k→k+1. The register file captures rf_data at edge k+1.
- Handshake:
  - The requester sees ackN=1 at edge k+1.
  - From that edge it either drops reqN or presents the next request (new addr/data).
  - Both behaviours are legal and need no idle cycle.
- Throughput:
  - One write per cycle while both requesters are active (alternating 0,1,0,1).
  - A single requester holding req continuously gets a write every other cycle, because of the ack mask.
- Fairness: under continuous contention, neither requester waits more than 1 cycle beyond its eligibility.
- write_count increments in the same edge that raises rf_we. It is visible with the write.

## Test plan
- Reset: assert reset 2 cycles with req0=req1=1 → all outputs 0 throughout. After release, first write is requester 0 (ack0=1, ack1=0).
- Single requester: req0=1, addr0=3, data0=8'hA5 at edge 1, dropped when ack0 seen → one cycle with rf_we=1, rf_addr=3, rf_data=A5, ack0=1, then rf_we=0. write_count=1.
- Contention: both request from edge 1 (addr0=1/data0=11, addr1=2/data1=22), each dropping req after its ack → writes 1←11 then 2←22 on consecutive cycles, write_count=2.
- Continuous contention with new data after each ack → grants alternate 0,1,0,1 for 8 cycles, rf_we high every cycle.
- Same address: both target addr 5 (data 0x0F and 0xF0) → two writes, 0x0F first then 0xF0, last_grant=1.
- Reset mid-write: reset asserted the cycle req1 is sampled → no ack1 and rf_we=0. After release, with req1 still held, requester 1 is written 1 cycle later.
- Saturation: CNT_W=2, issue 5 writes → write_count reads 1, 2, 3, 3, 3.
